// File: rtl/onehot_index_streamer.sv
// onehot_index_streamer
// Accepts a W-bit request vector and streams out the binary index of every
// set bit, lowest index first, one index per out_valid/out_ready handshake.
// An all-zero vector is still accepted. It produces no beats and raises a
// one-cycle zero_err pulse instead.

module onehot_index_streamer #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_bits,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          zero_err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   pending;
    logic [W-1:0]   pending_nxt;
    logic           zero_err_nxt;
    logic [IW-1:0]  low_idx;
    logic           single_bit;

    // Priority encoder: index of the lowest set bit of pending.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a variable unassigned would infer a latch.
        low_idx = '0;
        // Scanning from the top means the last match, which is the lowest set
        // bit, wins.
        for (int k = W - 1; k >= 0; k--) begin
            if (pending[k]) begin
                low_idx = IW'(k);
            end
        end
    end

    // Exactly one bit pending: x & (x-1) clears the lowest set bit.
    always_comb begin
        single_bit = (pending != '0) && ((pending & (pending - 1'b1)) == '0);
    end

    // Next-state, datapath and handshake outputs for the IDLE/EMIT controller.
    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        zero_err_nxt = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_idx      = '0;
        out_last     = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_bits != '0) begin
                        pending_nxt = in_bits;
                        state_nxt   = EMIT;
                    end else begin
                        zero_err_nxt = 1'b1;
                    end
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                out_idx   = low_idx;
                out_last  = single_bit;
                // pending only changes on a taken beat, so idx/last hold
                // steady under backpressure.
                if (out_ready) begin
                    pending_nxt = pending & (pending - 1'b1);
                    if (single_bit) begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
            end
        endcase
    end

    // State register. Reset returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending mask and zero-vector pulse. Reset drops any unsent bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            zero_err <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            zero_err <= zero_err_nxt;
        end
    end

endmodule
